dmem_ctrl: RTL and testbench

Data-memory load/store unit that sits directly downstream of the single-cycle datapath. It takes aluOut (address), readData2 (store data) and funct3 from the datapath, and drives a req/ack word-wide data memory port. It returns the extended load result as readDataDMem and asserts stall so the datapath holds its PC and register writes until the access completes. It also generates byte enables, handles sign/zero extension, and detects misaligned, illegal and timed-out accesses.

---
 rtl/dmem_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_dmem_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: load/store unit between the single-cycle datapath and a
// word-wide req/ack data memory.
//
// Ports:
//   clock, reset_          rising-edge clock, asynchronous active-low reset
//   memRead, memWrite      datapath asks for a load / store this instruction
//   funct3                 access size and extension (B, H, W, BU, HU)
//   aluOut                 byte address
//   readData2              store data, low bytes significant
//   readDataDMem           extended load result for writeback
//   stall                  datapath holds PC and suppresses regwrite while high
//   fault, faultCause      one-cycle fault pulse in DONE with its cause
//   mem_req .. mem_be      registered memory request channel
//   mem_rdata, mem_ack     memory response, only looked at in REQ
module dmem_ctrl #(
   parameter int TIMEOUT = 16,
   parameter int CNTW    = 5
) (
   input  logic        clock,
   input  logic        reset_,
   input  logic        memRead,
   input  logic        memWrite,
   input  logic [2:0]  funct3,
   input  logic [31:0] aluOut,
   input  logic [31:0] readData2,
   output logic [31:0] readDataDMem,
   output logic        stall,
   output logic        fault,
   output logic [1:0]  faultCause,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack
);

   typedef enum logic [1:0] {IDLE, REQ, DONE} stateT;

   localparam logic [CNTW-1:0] countLimit = CNTW'(TIMEOUT - 1);

   stateT           state;
   logic [CNTW-1:0] timeoutCount;
   logic [1:0]      addrLow;
   logic [2:0]      funct3Reg;

   logic        access;
   logic        illegal;
   logic        misaligned;
   logic [3:0]  beNext;
   logic [31:0] wdataNext;
   logic [31:0] loadData;

   assign access = memRead | memWrite;

   // The datapath must freeze from the moment an access shows up in IDLE
   // until the request has been answered; DONE lets the instruction retire.
   assign stall = ((state == IDLE) && access) || (state == REQ);

   // Decode the incoming instruction: legality, alignment, byte lanes and
   // lane-replicated store data. Illegal takes priority over misaligned so a
   // single cause is reported.
   always_comb begin
      illegal    = 1'b0;
      misaligned = 1'b0;
      beNext     = 4'b0000;
      wdataNext  = 32'h0;
      if ((funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111) ||
          (memWrite && funct3[2]) || (memRead && memWrite)) begin
         illegal = 1'b1;
      end
      case (funct3[1:0])
         2'b00: begin
            beNext    = 4'b0001 << aluOut[1:0];
            wdataNext = {4{readData2[7:0]}};
         end
         2'b01: begin
            beNext     = aluOut[1] ? 4'b1100 : 4'b0011;
            wdataNext  = {2{readData2[15:0]}};
            misaligned = aluOut[0];
         end
         2'b10: begin
            beNext     = 4'b1111;
            wdataNext  = readData2;
            misaligned = (aluOut[1:0] != 2'b00);
         end
         default: begin
            beNext    = 4'b0000;
            wdataNext = 32'h0;
         end
      endcase
      if (illegal) begin
         misaligned = 1'b0;
      end
   end

   // Pick the addressed byte or halfword out of the returned word using the
   // address bits and size latched at request time, then extend it.
   always_comb begin
      loadData = mem_rdata;
      case (funct3Reg)
         3'b000, 3'b100: begin
            case (addrLow)
               2'b00:   loadData = {24'h0, mem_rdata[7:0]};
               2'b01:   loadData = {24'h0, mem_rdata[15:8]};
               2'b10:   loadData = {24'h0, mem_rdata[23:16]};
               default: loadData = {24'h0, mem_rdata[31:24]};
            endcase
            if (!funct3Reg[2]) begin
               loadData[31:8] = {24{loadData[7]}};
            end
         end
         3'b001, 3'b101: begin
            loadData = addrLow[1] ? {16'h0, mem_rdata[31:16]} : {16'h0, mem_rdata[15:0]};
            if (!funct3Reg[2]) begin
               loadData[31:16] = {16{loadData[15]}};
            end
         end
         default: loadData = mem_rdata;
      endcase
   end

   // Main controller. All memory-side outputs, the fault pulse and the load
   // result are registered here. DONE always returns to IDLE so the access
   // still held by the datapath during DONE cannot retrigger a request. An
   // ack on the final counted cycle wins over the timeout.
   always_ff @(posedge clock or negedge reset_) begin
      if (!reset_) begin
         state        <= IDLE;
         mem_req      <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= 32'h0;
         mem_wdata    <= 32'h0;
         mem_be       <= 4'b0000;
         readDataDMem <= 32'h0;
         fault        <= 1'b0;
         faultCause   <= 2'b00;
         timeoutCount <= '0;
         addrLow      <= 2'b00;
         funct3Reg    <= 3'b000;
      end else begin
         case (state)
            IDLE: begin
               fault      <= 1'b0;
               faultCause <= 2'b00;
               if (access) begin
                  if (illegal || misaligned) begin
                     fault        <= 1'b1;
                     faultCause   <= illegal ? 2'b10 : 2'b01;
                     readDataDMem <= 32'h0;
                     state        <= DONE;
                  end else begin
                     mem_req      <= 1'b1;
                     mem_we       <= memWrite;
                     mem_addr     <= {aluOut[31:2], 2'b00};
                     mem_be       <= beNext;
                     mem_wdata    <= wdataNext;
                     addrLow      <= aluOut[1:0];
                     funct3Reg    <= funct3;
                     timeoutCount <= '0;
                     state        <= REQ;
                  end
               end
            end
            REQ: begin
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  if (!mem_we) begin
                     readDataDMem <= loadData;
                  end
                  state <= DONE;
               end else if (timeoutCount == countLimit) begin
                  mem_req      <= 1'b0;
                  fault        <= 1'b1;
                  faultCause   <= 2'b11;
                  readDataDMem <= 32'h0;
                  state        <= DONE;
               end else begin
                  timeoutCount <= timeoutCount + 1'b1;
               end
            end
            DONE: begin
               fault      <= 1'b0;
               faultCause <= 2'b00;
               state      <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: each access pushes its expected outcome
// into a scoreboard queue, and the entry is popped and compared when the
// controller reaches DONE.
module tb_dmem_ctrl;

   localparam int TIMEOUT = 16;

   logic        clock;
   logic        reset_;
   logic        memRead;
   logic        memWrite;
   logic [2:0]  funct3;
   logic [31:0] aluOut;
   logic [31:0] readData2;
   logic [31:0] readDataDMem;
   logic        stall;
   logic        fault;
   logic [1:0]  faultCause;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] rdata;
      logic        fault;
      logic [1:0]  cause;
      logic [31:0] addr;
      logic [3:0]  be;
      logic        we;
      logic [31:0] wdata;
      int          reqCycles;
   } expT;

   expT         sb[$];
   logic [31:0] lastRead = 32'h0;

   dmem_ctrl #(.TIMEOUT(TIMEOUT), .CNTW(5)) dut (
      .clock(clock), .reset_(reset_), .memRead(memRead), .memWrite(memWrite),
      .funct3(funct3), .aluOut(aluOut), .readData2(readData2),
      .readDataDMem(readDataDMem), .stall(stall), .fault(fault),
      .faultCause(faultCause), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   // Free-running 10 ns clock.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
      end
   endtask

   // Reference behaviour of one access, written from the access rules rather
   // than from the controller structure.
   function automatic expT model(input logic rd, input logic wr, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wd,
                                 input logic [31:0] rdata, input int ackDelay);
      expT         e;
      logic        bad;
      logic        mis;
      logic [31:0] sh;
      bad = (rd && wr) || (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (wr && f3[2]);
      mis = !bad && (((f3[1:0] == 2'd1) && addr[0]) || ((f3 == 3'd2) && (addr[1:0] != 2'd0)));
      e.addr  = addr & 32'hFFFF_FFFC;
      e.we    = wr;
      e.be    = (f3[1:0] == 2'd0) ? (4'h1 << addr[1:0]) :
                (f3[1:0] == 2'd1) ? (4'h3 << (addr[1] ? 2 : 0)) : 4'hF;
      e.wdata = (f3[1:0] == 2'd0) ? {wd[7:0], wd[7:0], wd[7:0], wd[7:0]} :
                (f3[1:0] == 2'd1) ? {wd[15:0], wd[15:0]} : wd;
      if (bad || mis) begin
         e.fault     = 1'b1;
         e.cause     = bad ? 2'd2 : 2'd1;
         e.reqCycles = 0;
         lastRead    = 32'h0;
      end else if (ackDelay < 0 || ackDelay >= TIMEOUT) begin
         e.fault     = 1'b1;
         e.cause     = 2'd3;
         e.reqCycles = TIMEOUT;
         lastRead    = 32'h0;
      end else begin
         e.fault     = 1'b0;
         e.cause     = 2'd0;
         e.reqCycles = ackDelay + 1;
         if (rd) begin
            if (f3[1:0] == 2'd0) begin
               sh = rdata >> (8 * addr[1:0]);
               lastRead = f3[2] ? (sh & 32'hFF) : {{24{sh[7]}}, sh[7:0]};
            end else if (f3[1:0] == 2'd1) begin
               sh = rdata >> (16 * addr[1]);
               lastRead = f3[2] ? (sh & 32'hFFFF) : {{16{sh[15]}}, sh[15:0]};
            end else begin
               lastRead = rdata;
            end
         end
      end
      e.rdata = lastRead;
      return e;
   endfunction

   // Drive one access, act as the memory (ack after ackDelay REQ cycles,
   // never if negative), then pop the scoreboard entry at DONE and compare.
   task automatic applyStimulus(input string name, input logic rd, input logic wr,
                                input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wd, input logic [31:0] rdata,
                                input int ackDelay);
      expT         e;
      int          reqCycles;
      int          cycles;
      logic        done;
      logic [31:0] capAddr;
      logic [31:0] capWdata;
      logic [3:0]  capBe;
      logic        capWe;
      sb.push_back(model(rd, wr, f3, addr, wd, rdata, ackDelay));
      @(negedge clock);
      memRead   = rd;
      memWrite  = wr;
      funct3    = f3;
      aluOut    = addr;
      readData2 = wd;
      mem_rdata = rdata;
      mem_ack   = 1'b0;
      #1 checkOutput({name, ".stallIdle"}, {31'h0, stall}, 32'h1);
      reqCycles = 0;
      cycles    = 0;
      done      = 1'b0;
      capAddr   = 32'h0;
      capWdata  = 32'h0;
      capBe     = 4'h0;
      capWe     = 1'b0;
      while (!done && cycles < 64) begin
         @(negedge clock);
         cycles++;
         if (mem_req) begin
            if (reqCycles == 0) begin
               capAddr  = mem_addr;
               capWdata = mem_wdata;
               capBe    = mem_be;
               capWe    = mem_we;
            end
            mem_ack = (ackDelay == reqCycles);
            reqCycles++;
         end else begin
            mem_ack = 1'b0;
            done    = 1'b1;
         end
      end
      checkOutput({name, ".finished"}, {31'h0, done}, 32'h1);
      e = sb.pop_front();
      checkOutput({name, ".stallDone"}, {31'h0, stall}, 32'h0);
      checkOutput({name, ".fault"}, {31'h0, fault}, {31'h0, e.fault});
      checkOutput({name, ".cause"}, {30'h0, faultCause}, {30'h0, e.cause});
      checkOutput({name, ".rdata"}, readDataDMem, e.rdata);
      checkOutput({name, ".reqCycles"}, reqCycles, e.reqCycles);
      if (e.reqCycles > 0) begin
         checkOutput({name, ".addr"}, capAddr, e.addr);
         checkOutput({name, ".be"}, {28'h0, capBe}, {28'h0, e.be});
         checkOutput({name, ".we"}, {31'h0, capWe}, {31'h0, e.we});
         if (e.we) begin
            checkOutput({name, ".wdata"}, capWdata, e.wdata);
         end
      end
      memRead  = 1'b0;
      memWrite = 1'b0;
      @(negedge clock);
      checkOutput({name, ".faultClr"}, {31'h0, fault}, 32'h0);
   endtask

   // Test sequence: reset values, loads and stores, faults, timeout with a
   // stray late ack, and asynchronous reset in the middle of a request.
   initial begin
      reset_    = 1'b0;
      memRead   = 1'b0;
      memWrite  = 1'b0;
      funct3    = 3'b000;
      aluOut    = 32'h0;
      readData2 = 32'h0;
      mem_rdata = 32'h0;
      mem_ack   = 1'b0;
      repeat (2) @(negedge clock);
      checkOutput("rst.req", {31'h0, mem_req}, 32'h0);
      checkOutput("rst.rdata", readDataDMem, 32'h0);
      checkOutput("rst.fault", {31'h0, fault}, 32'h0);
      checkOutput("rst.be", {28'h0, mem_be}, 32'h0);
      checkOutput("rst.stall", {31'h0, stall}, 32'h0);
      reset_ = 1'b1;

      applyStimulus("lw",     1, 0, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF, 0);
      applyStimulus("lb",     1, 0, 3'b000, 32'h13, 32'h0,        32'h80112233, 0);
      applyStimulus("lbu",    1, 0, 3'b100, 32'h13, 32'h0,        32'h80112233, 0);
      applyStimulus("lh",     1, 0, 3'b001, 32'h12, 32'h0,        32'h80112233, 0);
      applyStimulus("lhu",    1, 0, 3'b101, 32'h10, 32'h0,        32'h1234F00D, 2);
      applyStimulus("sb",     0, 1, 3'b000, 32'h21, 32'h000000A5, 32'h0,        0);
      applyStimulus("sh",     0, 1, 3'b001, 32'h22, 32'h0000BEEF, 32'h0,        0);
      applyStimulus("sw",     0, 1, 3'b010, 32'h30, 32'h12345678, 32'h0,        1);
      applyStimulus("lwMis",  1, 0, 3'b010, 32'h06, 32'h0,        32'h0,        0);
      applyStimulus("f3Ill",  1, 0, 3'b011, 32'h00, 32'h0,        32'h0,        0);
      applyStimulus("sbuIll", 0, 1, 3'b100, 32'h00, 32'h0,        32'h0,        0);
      applyStimulus("lhu2",   1, 0, 3'b101, 32'h16, 32'h0,        32'hCAFE0000, 0);
      applyStimulus("rwIll",  1, 1, 3'b010, 32'h00, 32'h0,        32'h0,        0);
      applyStimulus("lhMis",  1, 0, 3'b001, 32'h11, 32'h0,        32'h0,        0);
      applyStimulus("ackLast",1, 0, 3'b010, 32'h44, 32'h0,        32'h55AA55AA, TIMEOUT - 1);
      applyStimulus("tmo",    1, 0, 3'b010, 32'h48, 32'h0,        32'h0,        -1);

      // A late ack with no access pending must not start anything.
      mem_ack = 1'b1;
      repeat (2) @(negedge clock);
      checkOutput("stray.req", {31'h0, mem_req}, 32'h0);
      checkOutput("stray.stall", {31'h0, stall}, 32'h0);
      checkOutput("stray.fault", {31'h0, fault}, 32'h0);
      mem_ack = 1'b0;

      // Asynchronous reset while a request is outstanding.
      @(negedge clock);
      memRead = 1'b1;
      funct3  = 3'b010;
      aluOut  = 32'h40;
      repeat (3) @(negedge clock);
      checkOutput("midReset.reqBefore", {31'h0, mem_req}, 32'h1);
      #2;
      reset_  = 1'b0;
      memRead = 1'b0;
      #1;
      checkOutput("midReset.req", {31'h0, mem_req}, 32'h0);
      checkOutput("midReset.stall", {31'h0, stall}, 32'h0);
      checkOutput("midReset.rdata", readDataDMem, 32'h0);
      lastRead = 32'h0;
      mem_ack = 1'b1;
      @(negedge clock);
      reset_ = 1'b1;
      @(negedge clock);
      checkOutput("postReset.req", {31'h0, mem_req}, 32'h0);
      mem_ack = 1'b0;
      applyStimulus("lwAfterRst", 1, 0, 3'b010, 32'h40, 32'h0, 32'h0BADF00D, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
